// File: rtl/wb_retire.sv
// Write-back / retire stage: selects the write-back value, owns the register file,
// counts retired instructions and walks RUN -> DRAIN -> HALTED after a halting instruction.
module wb_retire #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        STALL,
  input  logic [1:0]  RWSrc,
  input  logic        RF_WE,
  input  logic        NUM_CHECK,
  input  logic        HALT,
  input  logic [31:0] ALUOUT,
  input  logic [31:0] ADD_PC,
  input  logic [31:0] D_MEM_DI,
  input  logic [4:0]  WA,
  input  logic [4:0]  RA1,
  input  logic [4:0]  RA2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] WB_DATA,
  output logic        WB_WE,
  output logic [31:0] NUM_INST,
  output logic        HALT_DONE,
  output logic [1:0]  STATE
);

  typedef enum logic [1:0] {
    S_RUN    = 2'b00,
    S_DRAIN  = 2'b01,
    S_HALTED = 2'b10
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  drain_cnt_q;
  logic [31:0] num_inst_q;
  logic        halt_done_q;
  logic [31:0] rf [32];

  // There is no valid/ready pair here: an instruction commits on a posedge where
  // STALL is low and the FSM is in RUN; STALL is the only back-pressure and freezes everything.
  always_comb begin
    WB_DATA = 32'h0;
    unique case (RWSrc)
      2'b00:   WB_DATA = ALUOUT;
      2'b01:   WB_DATA = D_MEM_DI;
      2'b10:   WB_DATA = ADD_PC;
      default: WB_DATA = 32'h0;
    endcase
  end

  assign WB_WE = RF_WE & ~STALL & (state_q == S_RUN) & ~HALT & (WA != 5'd0);

  // Read ports forward the value being written this cycle so ID sees it without a bubble.
  assign RD1 = (RA1 == 5'd0) ? 32'h0 : ((WB_WE && RA1 == WA) ? WB_DATA : rf[RA1]);
  assign RD2 = (RA2 == 5'd0) ? 32'h0 : ((WB_WE && RA2 == WA) ? WB_DATA : rf[RA2]);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (WB_WE) begin
      rf[WA] <= WB_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= S_RUN;
      drain_cnt_q <= 4'd0;
      num_inst_q  <= 32'h0;
      halt_done_q <= 1'b0;
    end else if (!STALL) begin
      unique case (state_q)
        S_RUN: begin
          // The halting instruction itself still retires and is counted.
          if (NUM_CHECK) num_inst_q <= num_inst_q + 32'd1;
          if (HALT) begin
            state_q     <= S_DRAIN;
            drain_cnt_q <= DRAIN_LOAD;
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == 4'd0) begin
            state_q     <= S_HALTED;
            halt_done_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign NUM_INST  = num_inst_q;
  assign HALT_DONE = halt_done_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_wb_retire.sv
// Randomized bench for wb_retire: a driver pushes expected per-cycle outputs from a
// behavioural model into a queue; a negedge monitor pops and compares.
module tb_wb_retire;

  localparam int DC = 2;
  localparam int W  = 132;

  logic        CLK, RSTn, STALL, RF_WE, NUM_CHECK, HALT;
  logic [1:0]  RWSrc;
  logic [31:0] ALUOUT, ADD_PC, D_MEM_DI;
  logic [4:0]  WA, RA1, RA2;
  logic [31:0] RD1, RD2, WB_DATA, NUM_INST;
  logic        WB_WE, HALT_DONE;
  logic [1:0]  STATE;

  wb_retire #(.DRAIN_CYCLES(DC)) dut (
    .CLK(CLK), .RSTn(RSTn), .STALL(STALL), .RWSrc(RWSrc), .RF_WE(RF_WE),
    .NUM_CHECK(NUM_CHECK), .HALT(HALT), .ALUOUT(ALUOUT), .ADD_PC(ADD_PC),
    .D_MEM_DI(D_MEM_DI), .WA(WA), .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
    .WB_DATA(WB_DATA), .WB_WE(WB_WE), .NUM_INST(NUM_INST), .HALT_DONE(HALT_DONE),
    .STATE(STATE)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #50 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  logic [W-1:0] exp_q[$];

  // behavioural model: architectural register contents, retired count, halt progress
  logic [31:0] m_rf [32];
  logic [31:0] m_count;
  bit          m_halted;
  int          m_drain;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_count  = 32'h0;
    m_halted = 1'b0;
    m_drain  = 0;
  endtask

  // driver: one cycle of stimulus, expectation pushed, model advanced past the edge
  task automatic drive(input logic stall, input logic [1:0] rwsrc, input logic we_req,
                       input logic numc, input logic halt, input logic [31:0] alu,
                       input logic [31:0] addpc, input logic [31:0] dmem,
                       input logic [4:0] wa, input logic [4:0] ra1, input logic [4:0] ra2);
    logic [31:0] sel, rd1, rd2;
    logic        we;
    logic [1:0]  ph;
    STALL = stall; RWSrc = rwsrc; RF_WE = we_req; NUM_CHECK = numc; HALT = halt;
    ALUOUT = alu; ADD_PC = addpc; D_MEM_DI = dmem; WA = wa; RA1 = ra1; RA2 = ra2;
    ph = !m_halted ? 2'b00 : ((m_drain < DC) ? 2'b01 : 2'b10);
    case (rwsrc)
      2'b00:   sel = alu;
      2'b01:   sel = dmem;
      2'b10:   sel = addpc;
      default: sel = 32'h0;
    endcase
    we  = we_req && !stall && (ph == 2'b00) && !halt && (wa != 5'd0);
    rd1 = (ra1 == 5'd0) ? 32'h0 : ((we && ra1 == wa) ? sel : m_rf[ra1]);
    rd2 = (ra2 == 5'd0) ? 32'h0 : ((we && ra2 == wa) ? sel : m_rf[ra2]);
    exp_q.push_back({sel, we, rd1, rd2, m_count, ph, (ph == 2'b10)});
    if (we) m_rf[wa] = sel;
    if (!stall) begin
      if (ph == 2'b00) begin
        if (numc) m_count = m_count + 32'd1;
        if (halt) begin
          m_halted = 1'b1;
          m_drain  = 0;
        end
      end else if (ph == 2'b01) begin
        m_drain++;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic rand_cycle(input bit allow_halt);
    logic [4:0] wa;
    wa = 5'($urandom_range(0, 31));
    drive($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) != 0, allow_halt && ($urandom_range(0, 19) == 0),
          $urandom, $urandom, $urandom, wa,
          ($urandom_range(0, 1) == 1) ? wa : 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)));
  endtask

  // asynchronous reset, checked between edges before any clock arrives
  task automatic do_reset();
    RSTn = 1'b0; RF_WE = 1'b0; STALL = 1'b0; HALT = 1'b0; NUM_CHECK = 1'b0;
    #1;
    check("rst_num_inst", NUM_INST, 32'h0);
    check("rst_state", 32'(STATE), 32'h0);
    check("rst_halt_done", 32'(HALT_DONE), 32'h0);
    for (int i = 0; i < 32; i++) begin
      RA1 = 5'(i); RA2 = 5'(31 - i);
      #1;
      check("rst_rd1", RD1, 32'h0);
      check("rst_rd2", RD2, 32'h0);
    end
    model_clear();
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK); #1;
  endtask

  // scoreboard monitor
  logic [W-1:0] e;
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("wb_data", WB_DATA, e[131:100]);
      check("wb_we", 32'(WB_WE), 32'(e[99]));
      check("rd1", RD1, e[98:67]);
      check("rd2", RD2, e[66:35]);
      check("num_inst", NUM_INST, e[34:3]);
      check("state", 32'(STATE), 32'(e[2:1]));
      check("halt_done", 32'(HALT_DONE), 32'(e[0]));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTn = 1'b0; STALL = 1'b0; RWSrc = 2'b00; RF_WE = 1'b0; NUM_CHECK = 1'b0; HALT = 1'b0;
    ALUOUT = 32'h0; ADD_PC = 32'h0; D_MEM_DI = 32'h0; WA = 5'd0; RA1 = 5'd0; RA2 = 5'd0;
    #5;
    do_reset();

    // load into x5 with bypass, then plain read
    drive(0, 2'b01, 1, 1, 0, 32'h0, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd0);
    drive(0, 2'b00, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
    // write to x0 is dropped but still counts
    drive(0, 2'b00, 1, 1, 0, 32'h1234, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    // stalled writes to x7
    repeat (3) drive(1, 2'b00, 1, 1, 0, 32'hA5A5_0007, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);
    drive(0, 2'b00, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0);
    // PC+4 and zero selects
    drive(0, 2'b10, 1, 1, 0, 32'h0, 32'h104, 32'h0, 5'd3, 5'd3, 5'd0);
    drive(0, 2'b11, 1, 1, 0, 32'hFFFF, 32'h104, 32'h55, 5'd4, 5'd4, 5'd3);

    repeat (300) rand_cycle(0);

    // counter wrap
    force dut.num_inst_q = 32'hFFFF_FFFE;
    #1;
    release dut.num_inst_q;
    m_count = 32'hFFFF_FFFE;
    drive(0, 2'b00, 0, 1, 0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    drive(0, 2'b00, 0, 1, 0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    drive(0, 2'b00, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

    // four commits then a halting write to x9, then ignored activity
    do_reset();
    for (int i = 1; i <= 4; i++)
      drive(0, 2'b00, 1, 1, 0, $urandom, 32'h0, 32'h0, 5'(i), 5'(i), 5'd9);
    drive(0, 2'b00, 1, 1, 1, 32'hCAFE_0009, 32'h0, 32'h0, 5'd9, 5'd9, 5'd1);
    repeat (6) drive(0, 2'b00, 1, 1, 1, 32'h1111_0009, 32'h0, 32'h0, 5'd9, 5'd9, 5'd2);

    // held-off halt under stall, then random traffic with halts and stalls
    do_reset();
    drive(1, 2'b00, 1, 1, 1, 32'h22, 32'h0, 32'h0, 5'd6, 5'd6, 5'd0);
    drive(0, 2'b00, 1, 1, 0, 32'h33, 32'h0, 32'h0, 5'd6, 5'd6, 5'd0);
    repeat (200) rand_cycle(1);

    // reset while draining
    do_reset();
    drive(0, 2'b00, 1, 1, 0, 32'h77, 32'h0, 32'h0, 5'd12, 5'd12, 5'd0);
    drive(0, 2'b00, 1, 1, 1, 32'h88, 32'h0, 32'h0, 5'd13, 5'd12, 5'd13);
    do_reset();
    repeat (40) rand_cycle(1);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge CLK);
    n_checks++;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_retire.md
WB_RETIRE -- requirements
Module: wb_retire

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2: cycles spent in DRAIN after a HALT commits before HALT_DONE asserts; legal range 1..15.
REQ-002 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-003 RSTn  in  1  reset; asynchronous, active-low.
REQ-004 STALL  in  1  freezes commit; no RF write, no count, no FSM advance while 1.
REQ-005 RWSrc  in  2  write-back select from the MEM/WB register.
REQ-006 RF_WE  in  1  register-file write request from the MEM/WB register.
REQ-007 NUM_CHECK  in  1  marks a valid (non-bubble) instruction in WB.
REQ-008 HALT  in  1  halting instruction in WB.
REQ-009 ALUOUT, ADD_PC, D_MEM_DI  in  32 each  ALU result, PC+4, load data.
REQ-010 WA  in  5  destination register.
REQ-011 RA1, RA2  in  5 each  ID-stage read addresses.
REQ-012 RD1, RD2  out  32 each  read data, combinational.
REQ-013 WB_DATA  out  32  selected write-back value, combinational.
REQ-014 WB_WE  out  1  effective write strobe this cycle, combinational.
REQ-015 NUM_INST  out  32  retired-instruction count, registered.
REQ-016 HALT_DONE  out  1  sticky halt-complete flag, registered.
REQ-017 STATE  out  2  FSM state: 00 RUN, 01 DRAIN, 10 HALTED.

Function
REQ-018 WB_DATA SHALL be ALUOUT for RWSrc=00, D_MEM_DI for 01, ADD_PC for 10, 32'h0 for 11.
REQ-019 WB_WE SHALL be RF_WE & ~STALL & (STATE==RUN) & ~HALT & (WA!=0).
REQ-020 Internal register file: 32 x 32-bit; x0 reads 0 always and is never written.
REQ-021 On posedge CLK with WB_WE=1, RF[WA] <= WB_DATA.
REQ-022 RD1/RD2 SHALL bypass: if WB_WE=1 and RAn==WA (nonzero), RDn = WB_DATA; else RF[RAn]; RAn=0 gives 0.
REQ-023 NUM_INST SHALL increment by 1 per cycle with NUM_CHECK=1, STALL=0, STATE=RUN; the halting instruction counts; wraps 32'hFFFFFFFF -> 0.
REQ-024 RUN -> DRAIN on posedge when HALT=1, STALL=0, STATE=RUN; drain counter loads DRAIN_CYCLES-1.
REQ-025 DRAIN: counter decrements each non-stalled cycle; at 0 next state HALTED; STALL holds counter and state.
REQ-026 HALTED: HALT_DONE=1; state held until reset; all inputs ignored except read ports.
REQ-027 In DRAIN and HALTED, RF writes and NUM_INST increments SHALL be suppressed regardless of RF_WE/NUM_CHECK.
REQ-028 HALT with STALL=1 SHALL be ignored that cycle (takes effect when STALL drops if still presented).
REQ-029 Latency: write visible via RF (not bypass) one cycle after commit; NUM_INST and STATE reflect commit at next edge.

Reset
REQ-030 RSTn=0 SHALL immediately, without a clock, clear all 32 RF entries, NUM_INST=0, HALT_DONE=0, STATE=RUN, drain counter=0.
REQ-031 Reset mid-DRAIN or in HALTED SHALL return to RUN with counts cleared; first commit allowed on the first posedge after RSTn rises.

Verification
REQ-032 Write x5: RWSrc=01, D_MEM_DI=32'hDEADBEEF, WA=5, RF_WE=1, NUM_CHECK=1, RA1=5 -> RD1=DEADBEEF same cycle (bypass), RF[5]=DEADBEEF next cycle, NUM_INST=1.
REQ-033 Write x0: WA=0, RF_WE=1, ALUOUT=32'h1234 -> WB_WE=0, RD1 with RA1=0 stays 0, NUM_INST still increments.
REQ-034 Stall: STALL=1 for 3 cycles with RF_WE=1, NUM_CHECK=1, WA=7 -> RF[7] unchanged, NUM_INST unchanged, WB_WE=0.
REQ-035 Halt: 4 committed instructions then HALT=1, NUM_CHECK=1, RF_WE=1, WA=9 -> NUM_INST=5, RF[9] unchanged, STATE 01 for 2 cycles, then 10 with HALT_DONE=1; later NUM_CHECK pulses leave NUM_INST=5.
REQ-036 Async reset: assert RSTn=0 between edges while in DRAIN -> STATE=00, HALT_DONE=0, NUM_INST=0, RF all zero before the next posedge.
REQ-037 Wrap and select: preload NUM_INST to FFFFFFFF via commits or force, one commit -> 0; RWSrc=10 with ADD_PC=32'h104 -> WB_DATA=104; RWSrc=11 -> WB_DATA=0.
